// File: rtl/req_pending_latch.sv
`default_nettype none
// ============================================================================
//  Module      : req_pending_latch
//  Description : Sticky pending latch for N request lines feeding a priority
//                encoder; ack clears one bit, overflow flags lost requests.
//                Optional macro REQ_SYNC_EN adds a 2-flop req synchroniser.
//  Revision    : 1.0 - initial release
// ============================================================================
module req_pending_latch #(
    parameter int N    = 8,
    parameter int EDGE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         mask,
    input  logic                 ack,
    input  logic [$clog2(N)-1:0] ack_idx,
    input  logic                 ovf_clr,
    output logic [N-1:0]         pending,
    output logic                 any_pending,
    output logic [N-1:0]         overflow
);

    localparam int c_IW = $clog2(N);

    logic [N-1:0] w_req_s;
    logic [N-1:0] r_req_q;
    logic [N-1:0] w_ev;
    logic [N-1:0] w_clr;
    logic [N-1:0] w_capt;
    logic [N-1:0] w_pend_nxt;
    logic [N-1:0] w_ovf_set;
    logic [N-1:0] w_ovf_nxt;
    logic [N-1:0] r_pending;
    logic [N-1:0] r_overflow;
    logic         r_any;

`ifdef REQ_SYNC_EN
    logic [N-1:0] r_sync1;
    logic [N-1:0] r_sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= req;
            r_sync2 <= r_sync1;
        end
    end

    assign w_req_s = r_sync2;
`else
    assign w_req_s = req;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_q <= '0;
        end else begin
            r_req_q <= w_req_s;
        end
    end

    generate
        if (EDGE != 0) begin : g_edge_detect
            assign w_ev = w_req_s & ~r_req_q;
        end else begin : g_level_detect
            assign w_ev = w_req_s;
        end
    endgenerate

    // Per-bit index compare: an ack_idx that matches no line clears nothing.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_clr
            assign w_clr[gi] = ack && (ack_idx == c_IW'(gi));
        end
    endgenerate

    assign w_capt     = w_ev & mask;
    assign w_pend_nxt = (r_pending & ~w_clr) | w_capt;
    assign w_ovf_set  = w_capt & r_pending & ~w_clr;
    assign w_ovf_nxt  = (ovf_clr ? '0 : r_overflow) | w_ovf_set;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending  <= '0;
            r_overflow <= '0;
            r_any      <= 1'b0;
        end else begin
            r_pending  <= w_pend_nxt;
            r_overflow <= w_ovf_nxt;
            r_any      <= |w_pend_nxt;
        end
    end

    assign pending     = r_pending;
    assign overflow    = r_overflow;
    assign any_pending = r_any;

endmodule
`default_nettype wire

// File: tb/tb_req_pending_latch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_req_pending_latch
//  Description : Directed scoreboard bench for req_pending_latch, one
//                edge-capture instance and one level-capture instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_req_pending_latch;

    typedef struct packed {
        logic [7:0] pend;
        logic       any;
        logic [7:0] ovf;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [7:0] req, mask;
    logic       ack, ovf_clr;
    logic [2:0] ack_idx;
    logic [7:0] pending, overflow;
    logic       any_pending;

    logic [7:0] req_l, mask_l;
    logic       ack_l, ovf_clr_l;
    logic [2:0] ack_idx_l;
    logic [7:0] pending_l, overflow_l;
    logic       any_pending_l;

    int checks = 0;
    int errors = 0;

    exp_t  sb_exp[$];
    string sb_tag[$];

    req_pending_latch #(.N(8), .EDGE(1)) dut (
        .clk(clk), .rst(rst), .req(req), .mask(mask), .ack(ack),
        .ack_idx(ack_idx), .ovf_clr(ovf_clr), .pending(pending),
        .any_pending(any_pending), .overflow(overflow)
    );

    req_pending_latch #(.N(8), .EDGE(0)) dut_lvl (
        .clk(clk), .rst(rst), .req(req_l), .mask(mask_l), .ack(ack_l),
        .ack_idx(ack_idx_l), .ovf_clr(ovf_clr_l), .pending(pending_l),
        .any_pending(any_pending_l), .overflow(overflow_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_out(input logic [7:0] p, input logic a, input logic [7:0] o);
        exp_t  e;
        string t;
        e = sb_exp.pop_front();
        t = sb_tag.pop_front();
        checks++;
        assert (p === e.pend) else begin
            errors++;
            $error("FAIL %s pending observed=%h expected=%h", t, p, e.pend);
        end
        checks++;
        assert (a === e.any) else begin
            errors++;
            $error("FAIL %s any_pending observed=%b expected=%b", t, a, e.any);
        end
        checks++;
        assert (o === e.ovf) else begin
            errors++;
            $error("FAIL %s overflow observed=%h expected=%h", t, o, e.ovf);
        end
    endtask

    // Drive edge-capture instance for one clock, then compare after the edge.
    task automatic step(input string tag, input logic r_st, input logic [7:0] r,
                        input logic [7:0] m, input logic a, input logic [2:0] ai,
                        input logic oc, input logic [7:0] ep, input logic [7:0] eo);
        rst = r_st; req = r; mask = m; ack = a; ack_idx = ai; ovf_clr = oc;
        sb_exp.push_back('{pend: ep, any: (ep != 8'h00), ovf: eo});
        sb_tag.push_back(tag);
        @(posedge clk);
        #1;
        check_out(pending, any_pending, overflow);
    endtask

    task automatic step_lvl(input string tag, input logic [7:0] r, input logic a,
                            input logic [2:0] ai, input logic oc,
                            input logic [7:0] ep, input logic [7:0] eo);
        req_l = r; ack_l = a; ack_idx_l = ai; ovf_clr_l = oc;
        sb_exp.push_back('{pend: ep, any: (ep != 8'h00), ovf: eo});
        sb_tag.push_back(tag);
        @(posedge clk);
        #1;
        check_out(pending_l, any_pending_l, overflow_l);
    endtask

    initial begin
        logic [7:0] e;
        rst = 1'b1; req = 8'hFF; mask = 8'hFF; ack = 1'b0; ack_idx = 3'd0; ovf_clr = 1'b0;
        req_l = 8'h00; mask_l = 8'hFF; ack_l = 1'b0; ack_idx_l = 3'd0; ovf_clr_l = 1'b0;
        #2;

        // Reset with all requests high, then release: held lines yield one event.
        step("rst_a",   1, 8'hFF, 8'hFF, 0, 3'd0, 0, 8'h00, 8'h00);
        step("rst_b",   1, 8'hFF, 8'hFF, 0, 3'd0, 0, 8'h00, 8'h00);
        step("release", 0, 8'hFF, 8'hFF, 0, 3'd0, 0, 8'hFF, 8'h00);
        for (int i = 0; i < 8; i++) begin
            e = 8'hFF << (i + 1);
            step($sformatf("ack_all_%0d", i), 0, 8'hFF, 8'hFF, 1, 3'(i), 0, e, 8'h00);
        end
        step("idle0",   0, 8'h00, 8'hFF, 0, 3'd0, 0, 8'h00, 8'h00);

        // Single pulse capture and ack.
        step("pulse5",  0, 8'h20, 8'hFF, 0, 3'd0, 0, 8'h20, 8'h00);
        step("ack5",    0, 8'h00, 8'hFF, 1, 3'd5, 0, 8'h00, 8'h00);

        // Overflow on re-rise while pending, then ovf_clr.
        step("set3",    0, 8'h08, 8'hFF, 0, 3'd0, 0, 8'h08, 8'h00);
        step("low3",    0, 8'h00, 8'hFF, 0, 3'd0, 0, 8'h08, 8'h00);
        step("ovf3",    0, 8'h08, 8'hFF, 0, 3'd0, 0, 8'h08, 8'h08);
        step("ovfclr",  0, 8'h00, 8'hFF, 0, 3'd0, 1, 8'h08, 8'h00);
        step("low3b",   0, 8'h00, 8'hFF, 0, 3'd0, 0, 8'h08, 8'h00);
        step("ovf3b",   0, 8'h08, 8'hFF, 0, 3'd0, 1, 8'h08, 8'h08);
        step("ack3",    0, 8'h00, 8'hFF, 1, 3'd3, 1, 8'h00, 8'h00);

        // Ack and new event on the same bit: set wins, no overflow.
        step("set2",    0, 8'h04, 8'hFF, 0, 3'd0, 0, 8'h04, 8'h00);
        step("low2",    0, 8'h00, 8'hFF, 0, 3'd0, 0, 8'h04, 8'h00);
        step("ackset2", 0, 8'h04, 8'hFF, 1, 3'd2, 0, 8'h04, 8'h00);
        step("ack2",    0, 8'h00, 8'hFF, 1, 3'd2, 0, 8'h00, 8'h00);
        step("ack_np6", 0, 8'h00, 8'hFF, 1, 3'd6, 0, 8'h00, 8'h00);

        // Masked edges are dropped and not recaptured once the mask opens.
        step("mask_lo", 0, 8'hF0, 8'h0F, 0, 3'd0, 0, 8'h00, 8'h00);
        step("mask_op", 0, 8'hF0, 8'hFF, 0, 3'd0, 0, 8'h00, 8'h00);
        step("idle1",   0, 8'h00, 8'hFF, 0, 3'd0, 0, 8'h00, 8'h00);

        // Closing the mask keeps already-pending bits.
        step("set0",    0, 8'h01, 8'hFF, 0, 3'd0, 0, 8'h01, 8'h00);
        step("mskhold", 0, 8'h00, 8'h00, 0, 3'd0, 0, 8'h01, 8'h00);
        step("ack0",    0, 8'h00, 8'h00, 1, 3'd0, 0, 8'h00, 8'h00);

        // Mid-operation reset discards pending and overflow.
        step("set1",    0, 8'h02, 8'hFF, 0, 3'd0, 0, 8'h02, 8'h00);
        step("low1",    0, 8'h00, 8'hFF, 0, 3'd0, 0, 8'h02, 8'h00);
        step("ovf1",    0, 8'h02, 8'hFF, 0, 3'd0, 0, 8'h02, 8'h02);
        step("midrst",  1, 8'h00, 8'hFF, 1, 3'd4, 0, 8'h00, 8'h00);
        step("postrst", 0, 8'h00, 8'hFF, 0, 3'd0, 0, 8'h00, 8'h00);

        // Level capture: a held line re-pends every clock despite acks.
        step_lvl("lvl_set",  8'h02, 0, 3'd0, 0, 8'h02, 8'h00);
        for (int i = 0; i < 3; i++) begin
            step_lvl($sformatf("lvl_ack_%0d", i), 8'h02, 1, 3'd1, 0, 8'h02, 8'h00);
        end
        step_lvl("lvl_ovf",  8'h02, 0, 3'd0, 0, 8'h02, 8'h02);
        step_lvl("lvl_drop", 8'h00, 1, 3'd1, 1, 8'h00, 8'h00);

        checks++;
        assert (sb_exp.size() == 0) else begin
            errors++;
            $error("FAIL sb_drain observed=%0d expected=0", sb_exp.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
